// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol encodings, FSM states, timing multipliers
// and pair-extraction helpers used by the transmitter and the decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        DOT   = 2'b01,
        DASH  = 2'b10,
        TERM  = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        LGAP  = 2'd3
    } state_t;

    // Interval lengths in Morse time units
    localparam logic [1:0] MULT_DOT       = 2'd1;
    localparam logic [1:0] MULT_SPACE     = 2'd1;
    localparam logic [1:0] MULT_MARK_DASH = 2'd3;
    localparam logic [1:0] MULT_LGAP      = 2'd3;

    // Pair idx=3 is bits [7:6], idx=0 is bits [1:0]
    function automatic sym_t pair_of(input logic [7:0] code, input logic [1:0] idx);
        return sym_t'(code[{idx, 1'b0} +: 2]);
    endfunction

    function automatic logic is_mark(input sym_t s);
        return (s == DOT) || (s == DASH);
    endfunction

    function automatic logic [1:0] mark_units(input sym_t s);
        return (s == DASH) ? MULT_MARK_DASH : MULT_DOT;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Interval timer counted in Morse units: load with a unit count, expire is
// asserted during the last clock cycle of the loaded interval.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] units,
    output logic       expire
);

    localparam int DUR_W = $clog2(3 * UNIT_CYCLES + 1);
    localparam int PH_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    logic [DUR_W-1:0] cnt_reg;
    logic [DUR_W-1:0] load_val;
    logic [PH_W-1:0]  phase_reg;
    logic             active_reg;
    logic             tick;

    // Remaining cycles minus one, so cnt_reg==0 marks the final cycle
    assign load_val = DUR_W'(units) * DUR_W'(UNIT_CYCLES) - DUR_W'(1);
    assign tick     = active_reg && (phase_reg == PH_W'(UNIT_CYCLES - 1));
    assign expire   = tick && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            phase_reg  <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            cnt_reg    <= load_val;
            phase_reg  <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (expire) begin
                active_reg <= 1'b0;
            end else begin
                cnt_reg   <= cnt_reg - DUR_W'(1);
                phase_reg <= tick ? '0 : phase_reg + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/morse_transmitter.sv
// Morse character keyer: sends the dot/dash pairs of an 8-bit code on key_out
// with inter-symbol spaces and a trailing letter gap, then pulses done.
module morse_transmitter #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] morse_array,
    input  logic       new_input_ready,
    output logic       ready,
    output logic       key_out,
    output logic       done
);
    import morse_pkg::*;

    state_t     state_reg, state_next;
    logic [7:0] code_reg, code_next;
    logic [1:0] idx_reg, idx_next;
    logic       key_out_reg, ready_reg, done_reg, done_next;

    logic       timer_load;
    logic [1:0] timer_units;
    logic       timer_expire;

    logic [3:0] pair_nz;
    logic       first_valid;
    logic [1:0] first_idx;
    sym_t       first_sym;
    sym_t       cur_sym;
    sym_t       nxt_sym;
    logic [1:0] nxt_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pair_nz
            assign pair_nz[gi] = |morse_array[2*gi +: 2];
        end
    endgenerate

    // Ascending scan so the highest-order non-empty pair wins
    always_comb begin
        first_valid = 1'b0;
        first_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pair_nz[i]) begin
                first_valid = 1'b1;
                first_idx   = 2'(i);
            end
        end
    end

    assign first_sym = pair_of(morse_array, first_idx);
    assign cur_sym   = pair_of(code_reg, idx_reg);
    assign nxt_idx   = idx_reg - 2'd1;
    assign nxt_sym   = pair_of(code_reg, nxt_idx);

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .units  (timer_units),
        .expire (timer_expire)
    );

    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        idx_next    = idx_reg;
        done_next   = 1'b0;
        timer_load  = 1'b0;
        timer_units = MULT_DOT;
        case (state_reg)
            IDLE: begin
                if (new_input_ready) begin
                    code_next  = morse_array;
                    timer_load = 1'b1;
                    if (first_valid && is_mark(first_sym)) begin
                        state_next  = MARK;
                        idx_next    = first_idx;
                        timer_units = mark_units(first_sym);
                    end else begin
                        state_next  = LGAP;
                        idx_next    = 2'd0;
                        timer_units = MULT_LGAP;
                    end
                end
            end
            MARK: begin
                if (timer_expire) begin
                    timer_load = 1'b1;
                    // An empty or terminator pair ends the character early
                    if (idx_reg != 2'd0 && is_mark(nxt_sym)) begin
                        state_next  = SPACE;
                        idx_next    = nxt_idx;
                        timer_units = MULT_SPACE;
                    end else begin
                        state_next  = LGAP;
                        timer_units = MULT_LGAP;
                    end
                end
            end
            SPACE: begin
                if (timer_expire) begin
                    state_next  = MARK;
                    timer_load  = 1'b1;
                    timer_units = mark_units(cur_sym);
                end
            end
            LGAP: begin
                if (timer_expire) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_reg
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            code_reg    <= 8'd0;
            idx_reg     <= 2'd0;
            key_out_reg <= 1'b0;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            idx_reg     <= idx_next;
            key_out_reg <= (state_next == MARK);
            ready_reg   <= (state_next == IDLE);
            done_reg    <= done_next;
        end
    end

    assign key_out = key_out_reg;
    assign ready   = ready_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_morse_transmitter.sv
// Directed bench for morse_transmitter at UNIT_CYCLES=2: per-character
// key/ready/done waveforms versus hand-built cycle masks, plus a reset abort.
module tb_morse_transmitter;

    localparam int UNIT = 2;
    localparam int MAXC = 48;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] morse_array;
    logic       new_input_ready;
    logic       ready;
    logic       key_out;
    logic       done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    morse_transmitter #(
        .UNIT_CYCLES (UNIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .morse_array     (morse_array),
        .new_input_ready (new_input_ready),
        .ready           (ready),
        .key_out         (key_out),
        .done            (done)
    );

    typedef struct {
        logic [7:0]  code;
        logic [63:0] key;
        int          done_cyc;
        int          busy_cyc;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit_at(input int n);
        logic [63:0] m;
        m = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at the negedge of a cycle where ready is expected high (idle or done cycle)
    task automatic run_vec(input vec_t v, input int n);
        logic [63:0] key_m, done_m, rdy_m;
        key_m = '0;
        done_m = '0;
        rdy_m = '0;
        key_m[0] = key_out;
        rdy_m[0] = ready;
        morse_array = v.code;
        new_input_ready = 1'b1;
        for (int c = 1; c < MAXC; c++) begin
            @(negedge clk);
            key_m[c]  = key_out;
            rdy_m[c]  = ready;
            done_m[c] = done;
            new_input_ready = (c == v.busy_cyc);
            morse_array = (c == v.busy_cyc) ? 8'hAA : ~v.code;
            if (done) break;
        end
        $display("[TB] vec %0d code=%h key=%h done=%h ready=%h", n, v.code, key_m, done_m, rdy_m);
        check($sformatf("key[%0d]", n), key_m, v.key);
        check($sformatf("done[%0d]", n), done_m, bit_at(v.done_cyc));
        check($sformatf("ready[%0d]", n), rdy_m, bit_at(0) | bit_at(v.done_cyc));
    endtask

    initial begin
        logic [63:0] pre;
        logic        any_key, any_done, all_rdy;

        vecs[0]  = '{8'h01, rng(1, 2), 9, 0};
        vecs[1]  = '{8'h06, rng(1, 2) | rng(5, 10), 17, 4};
        vecs[2]  = '{8'h99, rng(1, 6) | rng(9, 10) | rng(13, 18) | rng(21, 22), 29, 0};
        vecs[3]  = '{8'h99, rng(1, 6) | rng(9, 10) | rng(13, 18) | rng(21, 22), 29, 0};
        vecs[4]  = '{8'h00, 64'd0, 7, 3};
        vecs[5]  = '{8'hC1, 64'd0, 7, 0};
        vecs[6]  = '{8'h5D, rng(1, 2) | rng(5, 6), 13, 0};
        vecs[7]  = '{8'h80, rng(1, 6), 13, 0};
        vecs[8]  = '{8'h44, rng(1, 2), 9, 0};
        vecs[9]  = '{8'h55, rng(1, 2) | rng(5, 6) | rng(9, 10) | rng(13, 14), 21, 16};
        vecs[10] = '{8'hAA, rng(1, 6) | rng(9, 14) | rng(17, 22) | rng(25, 30), 37, 0};

        rst = 1'b1;
        new_input_ready = 1'b0;
        morse_array = 8'h00;
        repeat (3) @(negedge clk);
        $display("[TB] reset state ready=%b key=%b done=%b", ready, key_out, done);
        check("reset_state", {61'd0, ready, key_out, done}, 64'b100);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive vectors start on the previous done cycle (back-to-back)
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset during the first dash of Z, with a busy request in between
        @(negedge clk);
        pre = '0;
        morse_array = 8'hA5;
        new_input_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            pre[c] = key_out;
            new_input_ready = (c == 2);
            morse_array = (c == 2) ? 8'h01 : 8'h00;
            rst = (c == 3);
        end
        @(negedge clk);
        $display("[TB] Z abort pre=%h ready=%b key=%b done=%b", pre, ready, key_out, done);
        check("z_dash_before_reset", pre, rng(1, 3));
        check("after_reset", {61'd0, ready, key_out, done}, 64'b100);
        rst = 1'b0;
        any_key = 1'b0;
        any_done = 1'b0;
        all_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            any_key  = any_key | key_out;
            any_done = any_done | done;
            all_rdy  = all_rdy & ready;
        end
        $display("[TB] quiet after reset key=%b done=%b ready=%b", any_key, any_done, all_rdy);
        check("quiet_after_reset", {61'd0, any_key, any_done, all_rdy}, 64'b001);

        run_vec(vecs[0], 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_transmitter.md
MORSE_TRANSMITTER -- requirements
Module: morse_transmitter

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 12_500_000, meaning clock cycles per Morse time unit (legal range >= 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port morse_array  input  8  character code: four 2-bit symbol pairs, 01=dot, 10=dash, 00=empty, 11=terminator; first symbol is the highest-order non-00 pair, last is pair [1:0].
REQ-005 SHALL have port new_input_ready  input  1  request to send morse_array; sampled every cycle.
REQ-006 SHALL have port ready  output  1  high when idle and able to accept a character.
REQ-007 SHALL have port key_out  output  1  registered keying output: high = tone/mark, low = space.
REQ-008 SHALL have port done  output  1  one-cycle pulse on completion of a character including its letter gap.

Function
REQ-009 SHALL accept a character on a rising edge where new_input_ready=1 and ready=1, capturing morse_array in that edge; requests while ready=0 are ignored, not queued.
REQ-010 SHALL locate the first symbol at accept time as the highest-order non-00 pair (priority from pair [7:6] down to [1:0]).
REQ-011 SHALL use states IDLE, MARK, SPACE, LGAP; ready=1 only in IDLE; key_out=1 only in MARK.
REQ-012 SHALL, on accept with a dot/dash first symbol, enter MARK so key_out rises in the first cycle after the accept edge.
REQ-013 SHALL hold MARK for exactly 1*UNIT_CYCLES cycles for a dot and 3*UNIT_CYCLES for a dash.
REQ-014 SHALL, after a MARK whose symbol is not pair [1:0] and whose next pair is 01/10, enter SPACE for exactly 1*UNIT_CYCLES cycles, then MARK for the next lower pair.
REQ-015 SHALL treat pairs as ordered even if an inner pair is 00 or 11: reaching a 00 or 11 pair after the first symbol ends the character (enter LGAP, remaining pairs ignored).
REQ-016 SHALL, after the MARK of pair [1:0] or on early termination, enter LGAP for exactly 3*UNIT_CYCLES cycles with key_out=0.
REQ-017 SHALL, on accept of a code with no dot/dash first symbol (all 00, or leading non-00 pair is 11), enter LGAP directly; key_out never rises.
REQ-018 SHALL return to IDLE after LGAP; done=1 for exactly the first IDLE cycle, coincident with ready returning to 1.
REQ-019 SHALL accept new_input_ready=1 in the same cycle done=1 (back-to-back characters, no extra gap beyond LGAP).
REQ-020 SHALL size the duration counter as clog2(3*UNIT_CYCLES+1) bits, with no wrap within any legal interval.
REQ-021 SHALL ignore morse_array changes after the accept edge until the next accept.

Reset
REQ-022 SHALL, on any edge with rst=1, set state IDLE, ready=1, key_out=0, done=0, counters and captured code to 0.
REQ-023 SHALL give rst priority over new_input_ready; reset mid-character aborts it with no done pulse, and key_out=0 from the following cycle.

Structure
REQ-024 SHALL take symbol encodings (DOT, DASH, EMPTY, TERM), the state enum and gap multipliers (MARK_DASH=3, LGAP=3) from shared package morse_pkg, also used by morse_decoder.
REQ-025 SHALL place unit timing in one sub-module morse_unit_timer (load with unit count, tick per UNIT_CYCLES, expire flag); the FSM and pair selection stay in morse_transmitter.

Verification (UNIT_CYCLES=2, accept edge = cycle 0)
REQ-026 SHALL verify E 0x01: key_out high cycles 1-2, low 3-8, done=1 and ready=1 in cycle 9 only.
REQ-027 SHALL verify A 0x06: key_out high 1-2, low 3-4, high 5-10, low 11-16, done in cycle 17.
REQ-028 SHALL verify C 0x99 then immediate resend on the done cycle: key pattern 6/2/2/2/6/2/2 high/low widths, 6-cycle letter gap, second character's key_out rises the cycle after done.
REQ-029 SHALL verify 0x00 and 0xC1: key_out stays 0, done in cycle 7; and 0x5D (dot,dot,terminator): two dots then letter gap, pair [1:0] never sent.
REQ-030 SHALL verify rst=1 during the dash of Z 0xA5 and new_input_ready pulses while busy: key_out=0 and ready=1 the cycle after reset, no done, busy requests ignored.
